xpb_reduce_acc: RTL



---
 rtl/xpb_reduce_acc_pkg.sv | 23 ++
 rtl/xpb_reduce_acc_if.sv | 22 ++
 rtl/xpb_reduce_acc_csa_3to2.sv | 18 +
 rtl/xpb_reduce_acc.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/xpb_reduce_acc_pkg.sv
// Shared constants, FSM state type and helpers for the xpb residue accumulator.
package xpb_reduce_pkg;

    localparam int WORD_BITS  = 1024;
    localparam int OUT_BITS   = 1040;
    localparam int SEG_BITS   = 208;
    localparam int MAX_TERMS  = 64;
    localparam int NUM_SEG    = OUT_BITS / SEG_BITS;
    localparam int SEG_IDX_W  = $clog2(NUM_SEG);
    localparam int TERM_CNT_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE,
        DONE
    } state_t;

    function automatic logic [OUT_BITS-1:0] zext_word(input logic [WORD_BITS-1:0] w);
        return {{(OUT_BITS - WORD_BITS){1'b0}}, w};
    endfunction

endpackage

// File: rtl/xpb_reduce_acc_if.sv
// Input word stream plus result handshake between the xpb lookup and the next square stage.
interface xpb_reduce_acc_if;

    logic                                in_valid;
    logic                                in_ready;
    logic [xpb_reduce_pkg::WORD_BITS-1:0] in_data;
    logic                                in_last;
    logic                                out_valid;
    logic                                out_ready;
    logic [xpb_reduce_pkg::OUT_BITS-1:0]  out_data;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/xpb_reduce_acc_csa_3to2.sv
// Width-parameterised 3:2 carry-save compressor; carry is pre-shifted into its weight.
module csa_3to2 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    logic [WIDTH-1:0] maj;

    assign sum   = a ^ b ^ c;
    assign maj   = (a & b) | (a & c) | (b & c);
    assign carry = maj << 1;

endmodule

// File: rtl/xpb_reduce_acc.sv
// Carry-save accumulator of xpb residues with a segmented carry-propagate resolve.
// Optional term-count overflow flag enabled by defining XPB_REDUCE_ACC_TERM_CHECK_EN.
module xpb_reduce_acc
    import xpb_reduce_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    xpb_reduce_acc_if.slave bus,
    output logic           busy
`ifdef XPB_REDUCE_ACC_TERM_CHECK_EN
    ,
    output logic           term_err
`endif
);

    state_t                state_q;
    logic [OUT_BITS-1:0]   sum_q;
    logic [OUT_BITS-1:0]   carry_q;
    logic [SEG_IDX_W-1:0]  seg_idx_q;
    logic                  seg_done_q;
    logic                  cy_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [OUT_BITS-1:0]   out_data_q;
    logic                  busy_q;

    logic [OUT_BITS-1:0]   csa_sum;
    logic [OUT_BITS-1:0]   csa_carry;
    logic [SEG_BITS:0]     seg_total;
    logic                  xfer;

    assign xfer          = bus.in_valid && in_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;

    csa_3to2 #(
        .WIDTH (OUT_BITS)
    ) u_csa (
        .a     (sum_q),
        .b     (carry_q),
        .c     (zext_word(bus.in_data)),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

    // The resolve always works on the bottom segment; S and C rotate right so the
    // resolved segments wrap into the top and the full sum lands in place after NUM_SEG steps.
    assign seg_total = {1'b0, sum_q[SEG_BITS-1:0]}
                     + {1'b0, carry_q[SEG_BITS-1:0]}
                     + {{SEG_BITS{1'b0}}, cy_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            carry_q     <= '0;
            seg_idx_q   <= '0;
            seg_done_q  <= 1'b0;
            cy_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        sum_q      <= zext_word(bus.in_data);
                        carry_q    <= '0;
                        seg_idx_q  <= '0;
                        seg_done_q <= 1'b0;
                        cy_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        if (bus.in_last) begin
                            state_q    <= RESOLVE;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        sum_q   <= csa_sum;
                        carry_q <= csa_carry;
                        if (bus.in_last) begin
                            state_q    <= RESOLVE;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    if (!seg_done_q) begin
                        sum_q   <= {seg_total[SEG_BITS-1:0], sum_q[OUT_BITS-1:SEG_BITS]};
                        carry_q <= {{SEG_BITS{1'b0}}, carry_q[OUT_BITS-1:SEG_BITS]};
                        cy_q    <= seg_total[SEG_BITS];
                        if (seg_idx_q == SEG_IDX_W'(NUM_SEG - 1)) begin
                            seg_done_q <= 1'b1;
                        end else begin
                            seg_idx_q <= seg_idx_q + SEG_IDX_W'(1);
                        end
                    end else begin
                        out_data_q  <= sum_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef XPB_REDUCE_ACC_TERM_CHECK_EN
    logic [TERM_CNT_W-1:0] term_cnt_q;
    logic                  term_err_q;

    assign term_err = term_err_q;

    // The counter saturates at MAX_TERMS; any further accepted term latches the error.
    always_ff @(posedge clk) begin
        if (reset) begin
            term_cnt_q <= '0;
            term_err_q <= 1'b0;
        end else if (state_q == IDLE) begin
            term_cnt_q <= xfer ? TERM_CNT_W'(1) : '0;
        end else if (state_q == ACCUM && xfer) begin
            if (term_cnt_q == TERM_CNT_W'(MAX_TERMS)) begin
                term_err_q <= 1'b1;
            end else begin
                term_cnt_q <= term_cnt_q + TERM_CNT_W'(1);
            end
        end
    end
`endif

endmodule
